// File: rtl/riscv_apu_mult_slave_pkg.sv
// Shared types for the APU multiplier slave: op encoding, flag count, operand extension.
package apu_core_package;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } apu_mult_op_e;

  localparam int APU_SLAVE_NFLAGS = 2;

  function automatic logic [32:0] ext33(input logic [31:0] v, input logic sgn);
    return {sgn & v[31], v};
  endfunction

endpackage

// File: rtl/riscv_apu_mult_slave_if.sv
// Request/response bundle between the core-side APU dispatcher (master) and the multiplier (slave).
interface riscv_apu_mult_slave_if
  import apu_core_package::*;
#(
  parameter int TAG_WIDTH = 6
);
  logic                        apu_slave_req_i;
  logic                        apu_slave_gnt_o;
  apu_mult_op_e                apu_slave_op_i;
  logic [31:0]                 apu_slave_opa_i;
  logic [31:0]                 apu_slave_opb_i;
  logic [TAG_WIDTH-1:0]        apu_slave_tag_i;
  logic                        apu_slave_valid_o;
  logic                        apu_slave_ready_i;
  logic [31:0]                 apu_slave_result_o;
  logic [TAG_WIDTH-1:0]        apu_slave_tag_o;
  logic [APU_SLAVE_NFLAGS-1:0] apu_slave_flags_o;

  modport master (
    output apu_slave_req_i, apu_slave_op_i, apu_slave_opa_i, apu_slave_opb_i,
           apu_slave_tag_i, apu_slave_ready_i,
    input  apu_slave_gnt_o, apu_slave_valid_o, apu_slave_result_o,
           apu_slave_tag_o, apu_slave_flags_o
  );

  modport slave (
    input  apu_slave_req_i, apu_slave_op_i, apu_slave_opa_i, apu_slave_opb_i,
           apu_slave_tag_i, apu_slave_ready_i,
    output apu_slave_gnt_o, apu_slave_valid_o, apu_slave_result_o,
           apu_slave_tag_o, apu_slave_flags_o
  );
endinterface

// File: rtl/riscv_apu_mult_slave_fifo.sv
// Synchronous FIFO holding finished results that could not leave immediately.
module riscv_apu_slave_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [CW-1:0]    r_cnt;
  logic             w_push, w_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (r_cnt == '0);
  assign full_o  = (r_cnt == CW'(DEPTH));
  assign w_pop   = pop_i & ~empty_o;
  assign w_push  = push_i & (~full_o | w_pop);
  assign data_o  = r_mem[r_rd];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= nxt(r_wr);
      if (w_pop)  r_rd <= nxt(r_rd);
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr] <= data_i;
  end

endmodule

// File: rtl/riscv_apu_mult_slave.sv
// Shared 32b multiplier on the APU bus: fixed-latency pipeline plus in-order output buffer.
// Optional result flags (zero / MUL overflow) are enabled by defining APU_SLAVE_FLAGS_EN.
module riscv_apu_mult_slave
  import apu_core_package::*;
#(
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_WIDTH  = 6
) (
  input logic                   clk_i,
  input logic                   rst_i,
  riscv_apu_mult_slave_if.slave apu
);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
`ifdef APU_SLAVE_FLAGS_EN
  localparam int FLG_W = APU_SLAVE_NFLAGS;
`else
  localparam int FLG_W = 0;
`endif
  localparam int ENT_W = 32 + TAG_WIDTH + FLG_W;

  // Product kept as two partials (B low 16b, B high 17b) and summed after the final stage.
  typedef struct packed {
    apu_mult_op_e         op;
    logic [TAG_WIDTH-1:0] tag;
    logic [49:0]          pp_lo;
    logic [49:0]          pp_hi;
  } stage_t;

  logic                w_gnt, w_acc, w_pop, w_push, w_valid;
  logic [OCC_W-1:0]    r_occ;
  logic [LATENCY:1]    r_vld_pipe;
  stage_t              r_stg [LATENCY:1];
  stage_t              w_stg_in, w_fin;
  logic signed [32:0]  w_a33;
  logic signed [16:0]  w_blo, w_bhi;
  logic [63:0]         w_prod;
  logic [31:0]         w_res;
  logic [ENT_W-1:0]    w_fin_ent, w_head, w_out;
  logic                w_buf_empty, w_buf_full;

  assign w_gnt = !rst_i && (r_occ < OCC_W'(FIFO_DEPTH));
  assign w_acc = apu.apu_slave_req_i & w_gnt;

  always_comb begin
    w_a33          = $signed(ext33(apu.apu_slave_opa_i,
                                   apu.apu_slave_op_i inside {MULH, MULHSU}));
    w_blo          = $signed({1'b0, apu.apu_slave_opb_i[15:0]});
    w_bhi          = $signed({(apu.apu_slave_op_i == MULH) & apu.apu_slave_opb_i[31],
                               apu.apu_slave_opb_i[31:16]});
    w_stg_in.op    = apu.apu_slave_op_i;
    w_stg_in.tag   = apu.apu_slave_tag_i;
    w_stg_in.pp_lo = 50'(w_a33) * 50'(w_blo);
    w_stg_in.pp_hi = 50'(w_a33) * 50'(w_bhi);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld_pipe <= '0;
    end else begin
      r_vld_pipe[1] <= w_acc;
      for (int i = 2; i <= LATENCY; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    r_stg[1] <= w_stg_in;
    for (int i = 2; i <= LATENCY; i++) r_stg[i] <= r_stg[i-1];
  end

  // Bits above 63 of the true 66b product are never observed, so sum modulo 2^64.
  always_comb begin
    w_fin  = r_stg[LATENCY];
    w_prod = 64'($signed(w_fin.pp_lo)) + (64'($signed(w_fin.pp_hi)) << 16);
    w_res  = (w_fin.op == MUL) ? w_prod[31:0] : w_prod[63:32];
  end

`ifdef APU_SLAVE_FLAGS_EN
  logic [APU_SLAVE_NFLAGS-1:0] w_flags;
  always_comb begin
    w_flags[0] = (w_res == 32'd0);
    w_flags[1] = (w_fin.op == MUL) && (w_prod[63:32] != {32{w_prod[31]}});
  end
  assign w_fin_ent = {w_res, w_fin.tag, w_flags};
`else
  assign w_fin_ent = {w_res, w_fin.tag};
`endif

  assign w_valid = !rst_i && (!w_buf_empty || r_vld_pipe[LATENCY]);
  assign w_out   = w_buf_empty ? w_fin_ent : w_head;
  assign w_pop   = w_valid && apu.apu_slave_ready_i;
  // A final-stage op only skips the buffer when it is bypassed straight out.
  assign w_push  = r_vld_pipe[LATENCY] && !(w_buf_empty && w_pop);

  riscv_apu_slave_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .data_i  (w_fin_ent),
    .pop_i   (w_pop && !w_buf_empty),
    .data_o  (w_head),
    .empty_o (w_buf_empty),
    .full_o  (w_buf_full)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_occ <= '0;
    end else if (w_acc && !w_pop) begin
      r_occ <= r_occ + 1'b1;
    end else if (!w_acc && w_pop) begin
      r_occ <= r_occ - 1'b1;
    end
  end

  // Occupancy-based grant guarantees the buffer has room for every finishing op.
  always_ff @(posedge clk_i) begin
    if (!rst_i) assert (!(w_push && w_buf_full && !w_pop));
  end

  assign apu.apu_slave_gnt_o    = w_gnt;
  assign apu.apu_slave_valid_o  = w_valid;
  assign apu.apu_slave_result_o = w_valid ? w_out[ENT_W-1 -: 32] : '0;
  assign apu.apu_slave_tag_o    = w_valid ? w_out[FLG_W +: TAG_WIDTH] : '0;
`ifdef APU_SLAVE_FLAGS_EN
  assign apu.apu_slave_flags_o  = w_valid ? w_out[FLG_W-1:0] : '0;
`else
  assign apu.apu_slave_flags_o  = '0;
`endif

endmodule

// File: tb/tb_riscv_apu_mult_slave.sv
// Directed bench for riscv_apu_mult_slave: timing, back-pressure, arithmetic, reset, flags.
module tb_riscv_apu_mult_slave;
  import apu_core_package::*;

`ifdef APU_SLAVE_FLAGS_EN
  localparam bit FLG = 1'b1;
`else
  localparam bit FLG = 1'b0;
`endif

  logic clk, rst;
  int   n_chk, n_fail;

  riscv_apu_mult_slave_if #(.TAG_WIDTH(6)) bus ();

  riscv_apu_mult_slave #(
    .LATENCY    (2),
    .FIFO_DEPTH (4),
    .TAG_WIDTH  (6)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .apu   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    apu_mult_op_e op;
    logic [31:0]  a, b, res;
    logic [1:0]   fl;
  } vec_t;
  vec_t vt [8];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic drv(input logic req, input apu_mult_op_e op, input logic [31:0] a,
                     input logic [31:0] b, input logic [5:0] t);
    bus.apu_slave_req_i = req;
    bus.apu_slave_op_i  = op;
    bus.apu_slave_opa_i = a;
    bus.apu_slave_opb_i = b;
    bus.apu_slave_tag_i = t;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    vt[0] = '{MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2'b00};
    vt[1] = '{MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00};
    vt[2] = '{MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2'b00};
    vt[3] = '{MUL,    32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 2'b10};
    vt[4] = '{MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2'b01};
    vt[5] = '{MULH,   32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 2'b00};
    vt[6] = '{MUL,    32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 2'b11};
    vt[7] = '{MUL,    32'h0000_0002, 32'h0000_0003, 32'h0000_0006, 2'b00};

    rst = 1'b1;
    bus.apu_slave_ready_i = 1'b1;
    drv(1'b0, MUL, 0, 0, 0);

    // reset: outputs quiet and no grant even with a request pending
    tick();
    drv(1'b1, MUL, 32'd9, 32'd9, 6'd9);
    mid();
    chk("rst_gnt",    bus.apu_slave_gnt_o,    0);
    chk("rst_valid",  bus.apu_slave_valid_o,  0);
    chk("rst_result", bus.apu_slave_result_o, 0);
    chk("rst_tag",    bus.apu_slave_tag_o,    0);
    chk("rst_flags",  bus.apu_slave_flags_o,  0);
    tick();
    drv(1'b0, MUL, 0, 0, 0);

    // single MUL 3*5 tag 7
    for (int c = 0; c < 4; c++) begin
      tick();
      rst = 1'b0;
      if (c == 0) drv(1'b1, MUL, 32'd3, 32'd5, 6'd7);
      else        drv(1'b0, MUL, 0, 0, 0);
      mid();
      if (c == 0) chk("t1_gnt", bus.apu_slave_gnt_o, 1);
      if (c == 2) begin
        chk("t1_valid",  bus.apu_slave_valid_o,  1);
        chk("t1_result", bus.apu_slave_result_o, 15);
        chk("t1_tag",    bus.apu_slave_tag_o,    7);
      end else begin
        chk("t1_novalid", bus.apu_slave_valid_o, 0);
      end
    end

    // six back-to-back ops, results tag*(tag+1) in order
    for (int c = 0; c < 9; c++) begin
      tick();
      if (c < 6) drv(1'b1, MUL, 32'(c + 1), 32'(c + 2), 6'(c + 1));
      else       drv(1'b0, MUL, 0, 0, 0);
      mid();
      if (c < 6) chk("t2_gnt", bus.apu_slave_gnt_o, 1);
      if (c >= 2 && c <= 7) begin
        chk("t2_valid",  bus.apu_slave_valid_o,  1);
        chk("t2_tag",    bus.apu_slave_tag_o,    64'(c - 1));
        chk("t2_result", bus.apu_slave_result_o, 64'((c - 1) * c));
      end else begin
        chk("t2_novalid", bus.apu_slave_valid_o, 0);
      end
    end

    // back-pressure: 4 granted, 5th refused, drain one per cycle
    for (int c = 0; c < 11; c++) begin
      tick();
      bus.apu_slave_ready_i = (c >= 6);
      if (c < 5) drv(1'b1, MUL, 32'(c + 1), 32'd3, 6'(10 + c));
      else       drv(1'b0, MUL, 0, 0, 0);
      mid();
      if (c < 5)  chk("t3_gnt", bus.apu_slave_gnt_o, (c < 4) ? 64'd1 : 64'd0);
      if (c == 6) chk("t3_gnt_popcyc", bus.apu_slave_gnt_o, 0);
      if (c == 7) chk("t3_gnt_back",   bus.apu_slave_gnt_o, 1);
      if (c >= 2 && c <= 5) begin
        chk("t3_hold_valid",  bus.apu_slave_valid_o,  1);
        chk("t3_hold_tag",    bus.apu_slave_tag_o,    10);
        chk("t3_hold_result", bus.apu_slave_result_o, 3);
      end else if (c >= 6 && c <= 9) begin
        chk("t3_pop_valid",  bus.apu_slave_valid_o,  1);
        chk("t3_pop_tag",    bus.apu_slave_tag_o,    64'(10 + c - 6));
        chk("t3_pop_result", bus.apu_slave_result_o, 64'(3 * (c - 5)));
      end else begin
        chk("t3_novalid", bus.apu_slave_valid_o, 0);
      end
    end
    bus.apu_slave_ready_i = 1'b1;

    // arithmetic corners and flags
    for (int c = 0; c < 11; c++) begin
      tick();
      if (c < 8) drv(1'b1, vt[c].op, vt[c].a, vt[c].b, 6'(20 + c));
      else       drv(1'b0, MUL, 0, 0, 0);
      mid();
      if (c < 8) chk("t4_gnt", bus.apu_slave_gnt_o, 1);
      if (c >= 2 && c < 10) begin
        chk("t4_valid",  bus.apu_slave_valid_o,  1);
        chk("t4_tag",    bus.apu_slave_tag_o,    64'(20 + c - 2));
        chk("t4_result", bus.apu_slave_result_o, 64'(vt[c-2].res));
        chk("t4_flags",  bus.apu_slave_flags_o,  FLG ? 64'(vt[c-2].fl) : 64'd0);
      end else begin
        chk("t4_novalid", bus.apu_slave_valid_o, 0);
      end
    end

    // reset with two ops in flight drops them
    for (int c = 0; c < 7; c++) begin
      tick();
      rst = (c == 2);
      if (c < 2) drv(1'b1, MUL, 32'd4, 32'd4, 6'(30 + c));
      else       drv(1'b0, MUL, 0, 0, 0);
      mid();
      if (c < 2) chk("t5_gnt", bus.apu_slave_gnt_o, 1);
      if (c == 2) begin
        chk("t5_rst_gnt",    bus.apu_slave_gnt_o,    0);
        chk("t5_rst_result", bus.apu_slave_result_o, 0);
        chk("t5_rst_tag",    bus.apu_slave_tag_o,    0);
      end
      if (c == 3) chk("t5_gnt_after", bus.apu_slave_gnt_o, 1);
      chk("t5_novalid", bus.apu_slave_valid_o, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
